// File: rtl/ariane_pkg.sv
// ---------------------------------------------------------------------------
// ariane_pkg -- shared types for the write-back port arbiter.
//
// Contents:
//   XLEN, TRANS_ID_BITS : result data width and scoreboard index width
//   WB_ARB_NR_REQ       : default number of result-producing units
//   exception_t         : exception record travelling with each result
//   wb_req_t            : one write-back request {trans_id, data, ex}
// ---------------------------------------------------------------------------
package ariane_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;
  localparam int unsigned WB_ARB_NR_REQ = 6;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          data;
    exception_t               ex;
  } wb_req_t;

endpackage

// File: rtl/wb_rr_select.sv
// ---------------------------------------------------------------------------
// wb_rr_select -- combinational multi-grant rotating picker.
//
// Scans requesters cyclically starting at ptr_i and grants the first
// NR_WB_PORTS that are valid. The k-th grant in scan order is routed to
// port k.
//
// Ports:
//   valid_i    [NR_REQ]              request valid per unit
//   ptr_i      [PTR_W]               highest-priority requester index
//   grant_o    [NR_REQ]              granted units
//   sel_o      [NR_WB_PORTS][NR_REQ] per-port one-hot source select
//   last_idx_o [PTR_W]               index of the last granted unit
//                                    (equals ptr_i when nothing granted)
// ---------------------------------------------------------------------------
module wb_rr_select
  import ariane_pkg::*;
#(
  parameter int unsigned NR_REQ      = WB_ARB_NR_REQ,
  parameter int unsigned NR_WB_PORTS = 4,
  localparam int unsigned PTR_W      = $clog2(NR_REQ)
) (
  input  logic [NR_REQ-1:0]                   valid_i,
  input  logic [PTR_W-1:0]                    ptr_i,
  output logic [NR_REQ-1:0]                   grant_o,
  output logic [NR_WB_PORTS-1:0][NR_REQ-1:0]  sel_o,
  output logic [PTR_W-1:0]                    last_idx_o
);

  logic [PTR_W:0]   idx_sum;
  logic [PTR_W-1:0] idx;
  int unsigned      cnt;

  always_comb begin
    grant_o    = '0;
    sel_o      = '0;
    last_idx_o = ptr_i;
    idx_sum    = '0;
    idx        = '0;
    cnt        = 0;
    for (int unsigned o = 0; o < NR_REQ; o++) begin
      // One extra bit so ptr + offset can exceed NR_REQ before the wrap.
      idx_sum = {1'b0, ptr_i} + (PTR_W+1)'(o);
      if (idx_sum >= (PTR_W+1)'(NR_REQ)) begin
        idx_sum = idx_sum - (PTR_W+1)'(NR_REQ);
      end
      idx = idx_sum[PTR_W-1:0];
      if (valid_i[idx] && (cnt < NR_WB_PORTS)) begin
        grant_o[idx] = 1'b1;
        for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
          if (p == cnt) begin
            sel_o[p][idx] = 1'b1;
          end
        end
        last_idx_o = idx;
        cnt        = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter -- round-robin sharing of NR_WB_PORTS scoreboard
// write-back ports among NR_REQ result-producing functional units.
//
// Build option: define WB_ARB_OUTREG_EN to register the port bundle
// (1 cycle latency, flop outputs). Undefined: combinational output path.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   flush_i               drop pending grants and staged results
//   req_valid_i/ready_o   per-unit valid / grant handshake
//   req_trans_id_i, req_data_i, req_ex_i   per-unit result payload
//   trans_id_o, wbdata_o, ex_o, wt_valid_o per-port write-back bundle
// ---------------------------------------------------------------------------
module wb_port_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned NR_REQ      = WB_ARB_NR_REQ,
  parameter int unsigned NR_WB_PORTS = 4
) (
  input  logic                                      clk_i,
  input  logic                                      rst_ni,
  input  logic                                      flush_i,
  input  logic [NR_REQ-1:0]                         req_valid_i,
  output logic [NR_REQ-1:0]                         req_ready_o,
  input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0]      req_trans_id_i,
  input  logic [NR_REQ-1:0][XLEN-1:0]               req_data_i,
  input  exception_t [NR_REQ-1:0]                   req_ex_i,
  output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] trans_id_o,
  output logic [NR_WB_PORTS-1:0][XLEN-1:0]          wbdata_o,
  output exception_t [NR_WB_PORTS-1:0]              ex_o,
  output logic [NR_WB_PORTS-1:0]                    wt_valid_o
);

  localparam int unsigned PTR_W = $clog2(NR_REQ);

  logic [PTR_W-1:0]                   rr_q, rr_d;
  logic [PTR_W-1:0]                   last_idx;
  logic [NR_REQ-1:0]                  grant;
  logic [NR_WB_PORTS-1:0][NR_REQ-1:0] sel;
  wb_req_t [NR_REQ-1:0]               req;
  wb_req_t [NR_WB_PORTS-1:0]          port_req;
  logic [NR_WB_PORTS-1:0]             port_valid;
  wb_req_t [NR_WB_PORTS-1:0]          out_req;

  for (genvar gi = 0; gi < NR_REQ; gi++) begin : g_req
    assign req[gi] = '{trans_id: req_trans_id_i[gi],
                       data:     req_data_i[gi],
                       ex:       req_ex_i[gi]};
  end

  wb_rr_select #(
    .NR_REQ      (NR_REQ),
    .NR_WB_PORTS (NR_WB_PORTS)
  ) i_select (
    .valid_i    (req_valid_i),
    .ptr_i      (rr_q),
    .grant_o    (grant),
    .sel_o      (sel),
    .last_idx_o (last_idx)
  );

  // A flushed cycle grants nobody, so the units keep their results.
  assign req_ready_o = flush_i ? '0 : grant;

  always_comb begin
    rr_d = rr_q;
    if (!flush_i && (|grant)) begin
      rr_d = (last_idx == PTR_W'(NR_REQ - 1)) ? '0 : last_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  // Sel rows are one-hot, so an OR-reduction is a plain mux.
  always_comb begin
    port_req   = '0;
    port_valid = '0;
    for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
      port_valid[p] = |sel[p];
      for (int unsigned i = 0; i < NR_REQ; i++) begin
        if (sel[p][i]) begin
          port_req[p] = port_req[p] | req[i];
        end
      end
    end
  end

`ifdef WB_ARB_OUTREG_EN
  wb_req_t [NR_WB_PORTS-1:0] out_q;
  logic [NR_WB_PORTS-1:0]    wt_valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q      <= '0;
      wt_valid_q <= '0;
    end else begin
      out_q      <= port_req;
      wt_valid_q <= flush_i ? '0 : port_valid;
    end
  end

  assign out_req    = out_q;
  assign wt_valid_o = wt_valid_q;
`else
  assign out_req    = port_req;
  assign wt_valid_o = flush_i ? '0 : port_valid;
`endif

  for (genvar gi = 0; gi < NR_WB_PORTS; gi++) begin : g_port
    assign trans_id_o[gi] = out_req[gi].trans_id;
    assign wbdata_o[gi]   = out_req[gi].data;
    assign ex_o[gi]       = out_req[gi].ex;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  import ariane_pkg::*;

  localparam int N = 6;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [N-1:0] valid;
  logic [N-1:0] ready;
  logic [N-1:0][TRANS_ID_BITS-1:0] tid_in;
  logic [N-1:0][XLEN-1:0] data_in;
  exception_t [N-1:0] ex_in;
  logic [P-1:0][TRANS_ID_BITS-1:0] tid_out;
  logic [P-1:0][XLEN-1:0] data_out;
  exception_t [P-1:0] ex_out;
  logic [P-1:0] wt_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.NR_REQ(N), .NR_WB_PORTS(P)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .req_valid_i    (valid),
    .req_ready_o    (ready),
    .req_trans_id_i (tid_in),
    .req_data_i     (data_in),
    .req_ex_i       (ex_in),
    .trans_id_o     (tid_out),
    .wbdata_o       (data_out),
    .ex_o           (ex_out),
    .wt_valid_o     (wt_valid)
  );

  // Reference model: rotating priority list built from the arbitration rules.
  int         m_rr;
  int         exp_n;
  int         exp_idx [P];
  logic [N-1:0] exp_gnt;
  logic [TRANS_ID_BITS-1:0] exp_tid [P];
  logic [XLEN-1:0] exp_data [P];
  exception_t exp_ex [P];

  // Snapshots of DUT outputs taken at the proper sampling point.
  logic [N-1:0] snap_ready;
  logic [P-1:0] snap_pv;
  logic [P-1:0][TRANS_ID_BITS-1:0] snap_tid;
  logic [P-1:0][XLEN-1:0] snap_data;
  exception_t [P-1:0] snap_ex;
  logic [2:0] snap_rr;

  typedef struct {
    logic [N-1:0] valid;
    logic         flush;
    logic [N-1:0] exp_ready;
    logic [P-1:0] exp_pv;
    logic [P-1:0][2:0] exp_tid;
    int           exp_rr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_pick();
    int q[$];
    q = {};
    for (int k = 0; k < N; k++) begin
      if (valid[(m_rr + k) % N]) q.push_back((m_rr + k) % N);
    end
    exp_n   = flush ? 0 : ((q.size() < P) ? q.size() : P);
    exp_gnt = '0;
    for (int k = 0; k < exp_n; k++) begin
      exp_idx[k]      = q[k];
      exp_gnt[q[k]]   = 1'b1;
      exp_tid[k]      = tid_in[q[k]];
      exp_data[k]     = data_in[q[k]];
      exp_ex[k]       = ex_in[q[k]];
    end
  endtask

  task automatic model_advance();
    if (exp_n > 0) m_rr = (exp_idx[exp_n-1] + 1) % N;
  endtask

  task automatic take_snap();
    snap_pv   = wt_valid;
    snap_tid  = tid_out;
    snap_data = data_out;
    snap_ex   = ex_out;
  endtask

  // Called with inputs driven 2 time units after a rising edge.
  task automatic cycle();
    @(negedge clk);
    snap_ready = ready;
`ifndef WB_ARB_OUTREG_EN
    take_snap();
`endif
    @(posedge clk);
    #1;
`ifdef WB_ARB_OUTREG_EN
    take_snap();
`endif
    snap_rr = dut.rr_q;
    #1;
  endtask

  task automatic run_model_cycle(input string tag);
    model_pick();
    cycle();
    model_advance();
    chk({tag, " ready"}, 256'(snap_ready), 256'(exp_gnt));
    for (int p = 0; p < P; p++) begin
      if (p < exp_n)
        chk($sformatf("%s port%0d", tag, p),
            256'({snap_pv[p], snap_tid[p], snap_data[p], snap_ex[p]}),
            256'({1'b1, exp_tid[p], exp_data[p], exp_ex[p]}));
      else
        chk($sformatf("%s port%0d idle", tag, p), 256'(snap_pv[p]), 256'(0));
    end
    chk({tag, " rr"}, 256'(snap_rr), 256'(m_rr));
  endtask

  task automatic set_index_payload();
    for (int i = 0; i < N; i++) begin
      tid_in[i]  = TRANS_ID_BITS'(i);
      data_in[i] = 64'h1000 + 64'(i);
      ex_in[i]   = '0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{6'h3F, 1'b0, 6'h0F, 4'hF, {3'd3, 3'd2, 3'd1, 3'd0}, 4};
    vecs[1] = '{6'h3F, 1'b0, 6'h33, 4'hF, {3'd1, 3'd0, 3'd5, 3'd4}, 2};
    vecs[2] = '{6'h3C, 1'b0, 6'h3C, 4'hF, {3'd5, 3'd4, 3'd3, 3'd2}, 0};
    vecs[3] = '{6'h20, 1'b0, 6'h20, 4'h1, {3'd0, 3'd0, 3'd0, 3'd5}, 0};
    vecs[4] = '{6'h0F, 1'b1, 6'h00, 4'h0, {3'd0, 3'd0, 3'd0, 3'd0}, 0};
    vecs[5] = '{6'h0A, 1'b0, 6'h0A, 4'h3, {3'd0, 3'd0, 3'd3, 3'd1}, 4};
    vecs[6] = '{6'h00, 1'b0, 6'h00, 4'h0, {3'd0, 3'd0, 3'd0, 3'd0}, 4};
    vecs[7] = '{6'h3F, 1'b0, 6'h33, 4'hF, {3'd1, 3'd0, 3'd5, 3'd4}, 2};

    rst_n = 1'b0;
    flush = 1'b0;
    valid = '0;
    set_index_payload();
    m_rr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset wt_valid", 256'(wt_valid), 256'(0));
    chk("reset rr", 256'(dut.rr_q), 256'(0));
    #1;
    rst_n = 1'b1;

    // Idle after reset
    for (int c = 0; c < 10; c++) run_model_cycle($sformatf("idle%0d", c));

    // Table-driven vectors (trans_id = index)
    for (int v = 0; v < 8; v++) begin
      valid = vecs[v].valid;
      flush = vecs[v].flush;
      model_pick();
      cycle();
      model_advance();
      chk($sformatf("vec%0d ready", v), 256'(snap_ready), 256'(vecs[v].exp_ready));
      for (int p = 0; p < P; p++) begin
        if (vecs[v].exp_pv[p])
          chk($sformatf("vec%0d port%0d", v, p),
              256'({snap_pv[p], snap_tid[p]}), 256'({1'b1, vecs[v].exp_tid[p]}));
        else
          chk($sformatf("vec%0d port%0d idle", v, p), 256'(snap_pv[p]), 256'(0));
      end
      chk($sformatf("vec%0d rr", v), 256'(snap_rr), 256'(vecs[v].exp_rr));
    end
    flush = 1'b0;

    // Bring pointer back to 0 (only requester 5 valid), then exception routing
    valid = 6'h20;
    run_model_cycle("wrap5");
    valid = 6'h0A;
    data_in[3]     = 64'hDEAD;
    ex_in[3].valid = 1'b1;
    ex_in[3].cause = 64'h2;
    run_model_cycle("exc");
    chk("exc port0 tid", 256'(snap_tid[0]), 256'(1));
    chk("exc port1 tid", 256'(snap_tid[1]), 256'(3));
    chk("exc port1 ex.valid", 256'(snap_ex[1].valid), 256'(1));
    chk("exc port1 data", 256'(snap_data[1]), 256'(64'hDEAD));
    chk("exc port0 ex.valid", 256'(snap_ex[0].valid), 256'(0));

    // Randomized stream: pending requesters hold valid and payload until granted
    valid = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!valid[i] && ($urandom_range(0, 1) == 1)) begin
          valid[i]   = 1'b1;
          tid_in[i]  = TRANS_ID_BITS'($urandom_range(0, 7));
          data_in[i] = {$urandom, $urandom};
          ex_in[i]   = '{cause: 64'($urandom), tval: {$urandom, $urandom},
                         valid: 1'($urandom_range(0, 1))};
        end
      end
      flush = ($urandom_range(0, 15) == 0);
      run_model_cycle($sformatf("rnd%0d", c));
      for (int i = 0; i < N; i++) if (exp_gnt[i]) valid[i] = 1'b0;
    end
    flush = 1'b0;

    // Reset pulsed mid-stream
    set_index_payload();
    valid = '1;
    run_model_cycle("stream0");
    run_model_cycle("stream1");
    rst_n = 1'b0;
    #1;
    chk("midreset rr", 256'(dut.rr_q), 256'(0));
`ifdef WB_ARB_OUTREG_EN
    chk("midreset wt_valid", 256'(wt_valid), 256'(0));
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    m_rr = 0;
    run_model_cycle("restart");
    chk("restart ready", 256'(snap_ready), 256'(6'h0F));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
